// File: rtl/riscv_ex_stage.sv
// Execute stage: ALU, branch resolution, store lane alignment and a serial shift-add multiplier.
// A multiply occupies the stage for DATA_WIDTH enabled cycles while bubbles are emitted downstream.
module riscv_ex_stage #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      i_stall,
  input  logic                      i_valid_instr,
  input  logic [3:0]                i_alu_op,
  input  logic [3:0]                i_br_op,
  input  logic [DATA_WIDTH-1:0]     i_op_a,
  input  logic [DATA_WIDTH-1:0]     i_op_b,
  input  logic [ADDR_WIDTH-1:0]     i_pc,
  input  logic [DATA_WIDTH-1:0]     i_imm,
  input  logic [DATA_WIDTH-1:0]     i_rs2_data,
  input  logic [1:0]                i_mem_size,
  input  logic [4:0]                i_rd_addr,
  input  logic                      i_rd_write,
  input  logic                      i_read,
  input  logic                      i_write,
  input  logic                      i_wb_src,
  output logic                      o_busy,
  output logic                      o_redirect,
  output logic [ADDR_WIDTH-1:0]     o_redirect_pc,
  output logic                      o_valid_instr,
  output logic                      o_rd_write,
  output logic                      o_read,
  output logic                      o_write,
  output logic                      o_wb_src,
  output logic [DATA_WIDTH-1:0]     o_alu_data,
  output logic [DATA_WIDTH-1:0]     o_rs2_data,
  output logic [DATA_WIDTH/8-1:0]   o_mem_wr_strb,
  output logic [4:0]                o_rd_addr
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned SHW        = $clog2(DATA_WIDTH);
  localparam int unsigned CNT_W      = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;
  localparam logic [3:0] ALU_PASS = 4'd10;
  localparam logic [3:0] ALU_MUL  = 4'd11;

  localparam logic [3:0] BR_BEQ  = 4'd1;
  localparam logic [3:0] BR_BNE  = 4'd2;
  localparam logic [3:0] BR_BLT  = 4'd3;
  localparam logic [3:0] BR_BGE  = 4'd4;
  localparam logic [3:0] BR_BLTU = 4'd5;
  localparam logic [3:0] BR_BGEU = 4'd6;
  localparam logic [3:0] BR_JAL  = 4'd7;
  localparam logic [3:0] BR_JALR = 4'd8;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                 state, state_next;
  logic [CNT_W-1:0]       cnt, cnt_next;
  logic [DATA_WIDTH-1:0]  acc, acc_next;
  logic [DATA_WIDTH-1:0]  mcand, mcand_next;
  logic [DATA_WIDTH-1:0]  mplier, mplier_next;
  logic [4:0]             l_rd_addr, l_rd_addr_next;
  logic                   l_rd_write, l_rd_write_next;
  logic                   l_read, l_read_next;
  logic                   l_write, l_write_next;
  logic                   l_wb_src, l_wb_src_next;

  logic                   n_valid, n_rd_write, n_read, n_write, n_wb_src;
  logic [DATA_WIDTH-1:0]  n_alu, n_rs2;
  logic [STRB_WIDTH-1:0]  n_strb;
  logic [4:0]             n_rd_addr;

  logic                   accept;
  logic [SHW-1:0]         shamt;
  logic [DATA_WIDTH-1:0]  alu_res, ex_data, store_data, step_acc;
  logic [STRB_WIDTH-1:0]  store_strb;
  logic [7:0]             size_mask;
  logic [2:0]             byte_off;
  logic                   taken, is_jump;
  logic [ADDR_WIDTH-1:0]  br_target, jalr_target, target;

  assign accept = enable & ~i_stall & ~reset & (state == IDLE);
  assign shamt  = i_op_b[SHW-1:0];

  // Integer ALU; MUL is handled by the sequential multiplier, not here.
  always_comb begin
    alu_res = '0;
    case (i_alu_op)
      ALU_ADD:  alu_res = i_op_a + i_op_b;
      ALU_SUB:  alu_res = i_op_a - i_op_b;
      ALU_SLL:  alu_res = i_op_a << shamt;
      ALU_SLT:  alu_res = DATA_WIDTH'($signed(i_op_a) < $signed(i_op_b));
      ALU_SLTU: alu_res = DATA_WIDTH'(i_op_a < i_op_b);
      ALU_XOR:  alu_res = i_op_a ^ i_op_b;
      ALU_SRL:  alu_res = i_op_a >> shamt;
      ALU_SRA:  alu_res = $signed(i_op_a) >>> shamt;
      ALU_OR:   alu_res = i_op_a | i_op_b;
      ALU_AND:  alu_res = i_op_a & i_op_b;
      ALU_PASS: alu_res = i_op_b;
      default:  alu_res = '0;
    endcase
  end

  // Branch condition and target selection.
  always_comb begin
    taken   = 1'b0;
    is_jump = 1'b0;
    case (i_br_op)
      BR_BEQ:  taken = (i_op_a == i_op_b);
      BR_BNE:  taken = (i_op_a != i_op_b);
      BR_BLT:  taken = ($signed(i_op_a) < $signed(i_op_b));
      BR_BGE:  taken = ($signed(i_op_a) >= $signed(i_op_b));
      BR_BLTU: taken = (i_op_a < i_op_b);
      BR_BGEU: taken = (i_op_a >= i_op_b);
      BR_JAL, BR_JALR: begin
        taken   = 1'b1;
        is_jump = 1'b1;
      end
      default: taken = 1'b0;
    endcase
  end

  assign br_target   = i_pc + ADDR_WIDTH'($signed(i_imm));
  assign jalr_target = ADDR_WIDTH'(i_op_a + i_imm) & ~ADDR_WIDTH'(1);
  assign target      = (i_br_op == BR_JALR) ? jalr_target : br_target;
  assign ex_data     = is_jump ? DATA_WIDTH'(i_pc + ADDR_WIDTH'(4)) : alu_res;

  assign o_redirect    = accept & i_valid_instr & taken;
  assign o_redirect_pc = o_redirect ? target : '0;
  assign o_busy        = (state == BUSY);

  // Store lane alignment from the low address bits; strobes past the bus width fall off.
  always_comb begin
    case (i_mem_size)
      2'd0:    size_mask = 8'h01;
      2'd1:    size_mask = 8'h03;
      2'd2:    size_mask = 8'h0F;
      default: size_mask = 8'hFF;
    endcase
  end

  assign byte_off   = ex_data[2:0];
  assign store_strb = i_write ? STRB_WIDTH'((STRB_WIDTH + 8)'(size_mask) << byte_off) : '0;
  assign store_data = i_rs2_data << {byte_off, 3'b000};
  assign step_acc   = acc + (mplier[0] ? mcand : '0);

  // Next-state, multiplier datapath and output-register load values.
  always_comb begin
    state_next      = state;
    cnt_next        = cnt;
    acc_next        = acc;
    mcand_next      = mcand;
    mplier_next     = mplier;
    l_rd_addr_next  = l_rd_addr;
    l_rd_write_next = l_rd_write;
    l_read_next     = l_read;
    l_write_next    = l_write;
    l_wb_src_next   = l_wb_src;
    n_valid         = o_valid_instr;
    n_rd_write      = o_rd_write;
    n_read          = o_read;
    n_write         = o_write;
    n_wb_src        = o_wb_src;
    n_alu           = o_alu_data;
    n_rs2           = o_rs2_data;
    n_strb          = o_mem_wr_strb;
    n_rd_addr       = o_rd_addr;

    case (state)
      IDLE: begin
        if (!i_stall) begin
          if (i_valid_instr && (i_alu_op == ALU_MUL)) begin
            state_next      = BUSY;
            cnt_next        = '0;
            acc_next        = '0;
            mcand_next      = i_op_a;
            mplier_next     = i_op_b;
            l_rd_addr_next  = i_rd_addr;
            l_rd_write_next = i_rd_write;
            l_read_next     = i_read;
            l_write_next    = i_write;
            l_wb_src_next   = i_wb_src;
            n_valid         = 1'b0;
            n_rd_write      = 1'b0;
            n_read          = 1'b0;
            n_write         = 1'b0;
            n_wb_src        = 1'b0;
            n_alu           = '0;
            n_rs2           = '0;
            n_strb          = '0;
            n_rd_addr       = '0;
          end else begin
            n_valid    = i_valid_instr;
            n_rd_write = i_rd_write;
            n_read     = i_read;
            n_write    = i_write;
            n_wb_src   = i_wb_src;
            n_alu      = ex_data;
            n_rs2      = store_data;
            n_strb     = store_strb;
            n_rd_addr  = i_rd_addr;
          end
        end
      end
      BUSY: begin
        if (cnt != CNT_LAST) begin
          acc_next    = step_acc;
          mcand_next  = mcand << 1;
          mplier_next = mplier >> 1;
          cnt_next    = cnt + CNT_W'(1);
          if (!i_stall) begin
            n_valid    = 1'b0;
            n_rd_write = 1'b0;
            n_read     = 1'b0;
            n_write    = 1'b0;
            n_wb_src   = 1'b0;
            n_alu      = '0;
            n_rs2      = '0;
            n_strb     = '0;
            n_rd_addr  = '0;
          end
        end else if (!i_stall) begin
          // Last partial product folds straight into the result register.
          state_next = IDLE;
          cnt_next   = '0;
          acc_next   = step_acc;
          n_valid    = 1'b1;
          n_rd_write = l_rd_write;
          n_read     = l_read;
          n_write    = l_write;
          n_wb_src   = l_wb_src;
          n_alu      = step_acc;
          n_rs2      = '0;
          n_strb     = '0;
          n_rd_addr  = l_rd_addr;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State and output registers; enable low freezes everything except reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      acc           <= '0;
      mcand         <= '0;
      mplier        <= '0;
      l_rd_addr     <= '0;
      l_rd_write    <= 1'b0;
      l_read        <= 1'b0;
      l_write       <= 1'b0;
      l_wb_src      <= 1'b0;
      o_valid_instr <= 1'b0;
      o_rd_write    <= 1'b0;
      o_read        <= 1'b0;
      o_write       <= 1'b0;
      o_wb_src      <= 1'b0;
      o_alu_data    <= '0;
      o_rs2_data    <= '0;
      o_mem_wr_strb <= '0;
      o_rd_addr     <= '0;
    end else if (enable) begin
      state         <= state_next;
      cnt           <= cnt_next;
      acc           <= acc_next;
      mcand         <= mcand_next;
      mplier        <= mplier_next;
      l_rd_addr     <= l_rd_addr_next;
      l_rd_write    <= l_rd_write_next;
      l_read        <= l_read_next;
      l_write       <= l_write_next;
      l_wb_src      <= l_wb_src_next;
      o_valid_instr <= n_valid;
      o_rd_write    <= n_rd_write;
      o_read        <= n_read;
      o_write       <= n_write;
      o_wb_src      <= n_wb_src;
      o_alu_data    <= n_alu;
      o_rs2_data    <= n_rs2;
      o_mem_wr_strb <= n_strb;
      o_rd_addr     <= n_rd_addr;
    end
  end

endmodule

// File: tb/tb_riscv_ex_stage.sv
// Directed bench for riscv_ex_stage: vector table for single-cycle ops, hand sequences
// for stall/enable hold, the serial multiplier and reset during a multiply.
module tb_riscv_ex_stage;

  logic        clk = 1'b0;
  logic        reset, enable, i_stall, i_valid_instr;
  logic [3:0]  i_alu_op, i_br_op;
  logic [63:0] i_op_a, i_op_b, i_pc, i_imm, i_rs2_data;
  logic [1:0]  i_mem_size;
  logic [4:0]  i_rd_addr;
  logic        i_rd_write, i_read, i_write, i_wb_src;
  logic        o_busy, o_redirect;
  logic [63:0] o_redirect_pc;
  logic        o_valid_instr, o_rd_write, o_read, o_write, o_wb_src;
  logic [63:0] o_alu_data, o_rs2_data;
  logic [7:0]  o_mem_wr_strb;
  logic [4:0]  o_rd_addr;

  int total = 0;
  int bad   = 0;

  riscv_ex_stage dut (
    .clk(clk), .reset(reset), .enable(enable), .i_stall(i_stall),
    .i_valid_instr(i_valid_instr), .i_alu_op(i_alu_op), .i_br_op(i_br_op),
    .i_op_a(i_op_a), .i_op_b(i_op_b), .i_pc(i_pc), .i_imm(i_imm),
    .i_rs2_data(i_rs2_data), .i_mem_size(i_mem_size), .i_rd_addr(i_rd_addr),
    .i_rd_write(i_rd_write), .i_read(i_read), .i_write(i_write), .i_wb_src(i_wb_src),
    .o_busy(o_busy), .o_redirect(o_redirect), .o_redirect_pc(o_redirect_pc),
    .o_valid_instr(o_valid_instr), .o_rd_write(o_rd_write), .o_read(o_read),
    .o_write(o_write), .o_wb_src(o_wb_src), .o_alu_data(o_alu_data),
    .o_rs2_data(o_rs2_data), .o_mem_wr_strb(o_mem_wr_strb), .o_rd_addr(o_rd_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  alu_op;
    logic [3:0]  br_op;
    logic [63:0] a, b, pc, imm, rs2;
    logic [1:0]  size;
    logic        wr;
    logic [63:0] exp_alu;
    logic [7:0]  exp_strb;
    logic [63:0] exp_rs2;
    logic        exp_redir;
    logic [63:0] exp_tgt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [3:0] alu_op, logic [3:0] br_op, logic [63:0] a, logic [63:0] b,
                              logic [63:0] pc, logic [63:0] imm, logic [63:0] rs2, logic [1:0] size,
                              logic wr, logic [63:0] exp_alu, logic [7:0] exp_strb,
                              logic [63:0] exp_rs2, logic exp_redir, logic [63:0] exp_tgt);
    vec_t v;
    v.alu_op = alu_op; v.br_op = br_op; v.a = a; v.b = b; v.pc = pc; v.imm = imm;
    v.rs2 = rs2; v.size = size; v.wr = wr; v.exp_alu = exp_alu; v.exp_strb = exp_strb;
    v.exp_rs2 = exp_rs2; v.exp_redir = exp_redir; v.exp_tgt = exp_tgt;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle;
    i_valid_instr = 0; i_alu_op = 0; i_br_op = 0; i_op_a = 0; i_op_b = 0;
    i_pc = 0; i_imm = 0; i_rs2_data = 0; i_mem_size = 0; i_rd_addr = 0;
    i_rd_write = 0; i_read = 0; i_write = 0; i_wb_src = 0;
  endtask

  task automatic drive_op(input logic [3:0] alu_op, input logic [3:0] br_op,
                          input logic [63:0] a, input logic [63:0] b, input logic [4:0] rd);
    drive_idle();
    i_valid_instr = 1; i_alu_op = alu_op; i_br_op = br_op;
    i_op_a = a; i_op_b = b; i_rd_addr = rd; i_rd_write = 1;
  endtask

  initial begin
    int n;
    reset = 1; enable = 1; i_stall = 0;
    drive_idle();

    vecs.push_back(mk(4'd0, 0, 64'd5, -64'sd3, 0, 0, 0, 0, 0, 64'd2, 0, 0, 0, 0));
    vecs.push_back(mk(4'd1, 0, 64'd5, 64'd7, 0, 0, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFE, 0, 0, 0, 0));
    vecs.push_back(mk(4'd2, 0, 64'd1, 64'd65, 0, 0, 0, 0, 0, 64'd2, 0, 0, 0, 0));
    vecs.push_back(mk(4'd3, 0, -64'sd1, 64'd1, 0, 0, 0, 0, 0, 64'd1, 0, 0, 0, 0));
    vecs.push_back(mk(4'd4, 0, -64'sd1, 64'd1, 0, 0, 0, 0, 0, 64'd0, 0, 0, 0, 0));
    vecs.push_back(mk(4'd5, 0, 64'hF0, 64'hFF, 0, 0, 0, 0, 0, 64'h0F, 0, 0, 0, 0));
    vecs.push_back(mk(4'd6, 0, 64'h8000_0000_0000_0000, 64'd63, 0, 0, 0, 0, 0, 64'd1, 0, 0, 0, 0));
    vecs.push_back(mk(4'd7, 0, 64'h8000_0000_0000_0000, 64'd4, 0, 0, 0, 0, 0, 64'hF800_0000_0000_0000, 0, 0, 0, 0));
    vecs.push_back(mk(4'd8, 0, 64'hF0, 64'h0F, 0, 0, 0, 0, 0, 64'hFF, 0, 0, 0, 0));
    vecs.push_back(mk(4'd9, 0, 64'hF0, 64'h3C, 0, 0, 0, 0, 0, 64'h30, 0, 0, 0, 0));
    vecs.push_back(mk(4'd10, 0, 64'h99, 64'h1234, 0, 0, 0, 0, 0, 64'h1234, 0, 0, 0, 0));
    vecs.push_back(mk(4'd12, 0, 64'h5, 64'h6, 0, 0, 0, 0, 0, 64'd0, 0, 0, 0, 0));
    vecs.push_back(mk(4'd0, 0, 64'h1000, 64'd4, 0, 0, 64'hDEADBEEF, 2'd2, 1, 64'h1004, 8'hF0, 64'hDEADBEEF_0000_0000, 0, 0));
    vecs.push_back(mk(4'd0, 0, 64'h1000, 64'd1, 0, 0, 64'h1122334455667788, 2'd3, 1, 64'h1001, 8'hFE, 64'h2233445566778800, 0, 0));
    vecs.push_back(mk(4'd0, 0, 64'h7, 64'd0, 0, 0, 64'hAB, 2'd0, 1, 64'h7, 8'h80, 64'hAB00_0000_0000_0000, 0, 0));
    vecs.push_back(mk(4'd0, 0, 64'h6, 64'd0, 0, 0, 64'hBEEF, 2'd1, 1, 64'h6, 8'hC0, 64'hBEEF_0000_0000_0000, 0, 0));
    vecs.push_back(mk(4'd0, 0, 64'h7, 64'd0, 0, 0, 64'hBEEF, 2'd1, 1, 64'h7, 8'h80, 64'hEF00_0000_0000_0000, 0, 0));
    vecs.push_back(mk(4'd1, 4'd1, 64'd7, 64'd7, 64'h100, 64'h20, 0, 0, 0, 64'd0, 0, 0, 1, 64'h120));
    vecs.push_back(mk(4'd1, 4'd2, 64'd7, 64'd7, 64'h100, 64'h20, 0, 0, 0, 64'd0, 0, 0, 0, 0));
    vecs.push_back(mk(4'd1, 4'd3, -64'sd1, 64'd1, 64'h200, -64'sd8, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFE, 0, 0, 1, 64'h1F8));
    vecs.push_back(mk(4'd1, 4'd4, 64'd1, -64'sd1, 64'h0, 64'd4, 0, 0, 0, 64'd2, 0, 0, 1, 64'h4));
    vecs.push_back(mk(4'd1, 4'd5, -64'sd1, 64'd1, 64'h40, 64'h10, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFE, 0, 0, 0, 0));
    vecs.push_back(mk(4'd1, 4'd6, -64'sd1, 64'd1, 64'h40, 64'h10, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFE, 0, 0, 1, 64'h50));
    vecs.push_back(mk(4'd0, 4'd7, 64'h400, 64'h100, 64'h400, 64'h100, 0, 0, 0, 64'h404, 0, 0, 1, 64'h500));
    vecs.push_back(mk(4'd0, 4'd8, 64'h203, 64'h0, 64'h300, 64'h0, 0, 0, 0, 64'h304, 0, 0, 1, 64'h202));

    tick(); tick();
    chk("reset_busy", 64'(o_busy), 0);
    chk("reset_valid", 64'(o_valid_instr), 0);
    chk("reset_alu", o_alu_data, 0);
    chk("reset_strb", 64'(o_mem_wr_strb), 0);
    reset = 0;

    foreach (vecs[i]) begin
      drive_op(vecs[i].alu_op, vecs[i].br_op, vecs[i].a, vecs[i].b, 5'(i + 1));
      i_pc = vecs[i].pc; i_imm = vecs[i].imm; i_rs2_data = vecs[i].rs2;
      i_mem_size = vecs[i].size; i_write = vecs[i].wr; i_rd_write = ~vecs[i].wr;
      i_wb_src = 1'(i);
      #1;
      chk($sformatf("v%0d_redirect", i), 64'(o_redirect), 64'(vecs[i].exp_redir));
      chk($sformatf("v%0d_target", i), o_redirect_pc, vecs[i].exp_tgt);
      tick();
      chk($sformatf("v%0d_alu", i), o_alu_data, vecs[i].exp_alu);
      chk($sformatf("v%0d_strb", i), 64'(o_mem_wr_strb), 64'(vecs[i].exp_strb));
      chk($sformatf("v%0d_rs2", i), o_rs2_data, vecs[i].exp_rs2);
      chk($sformatf("v%0d_ctl", i),
          {59'd0, o_valid_instr, o_rd_write, o_write, o_wb_src, o_read},
          {59'd0, 1'b1, ~vecs[i].wr, vecs[i].wr, 1'(i), 1'b0});
      chk($sformatf("v%0d_rd", i), 64'(o_rd_addr), 64'(i + 1));
    end

    // Stall and enable-low hold the output registers and suppress redirect.
    drive_op(4'd0, 0, 64'd10, 64'd20, 5'd3);
    tick();
    chk("pre_stall_alu", o_alu_data, 64'd30);
    i_stall = 1;
    drive_op(4'd1, 4'd1, 64'd1, 64'd1, 5'd4);
    #1;
    chk("stall_redirect", 64'(o_redirect), 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall_hold", {o_alu_data[58:0], o_valid_instr, o_rd_addr}, {59'd30, 1'b1, 5'd3});
    end
    i_stall = 0; enable = 0;
    #1;
    chk("disable_redirect", 64'(o_redirect), 0);
    tick();
    chk("disable_hold", {o_alu_data[58:0], o_rd_addr}, {59'd30, 5'd3});
    enable = 1;
    tick();
    chk("release_load", {o_alu_data[58:0], o_rd_addr}, {59'd0, 5'd4});

    // Multiply 3 x -1: 64 busy cycles of bubbles, then the truncated product.
    drive_op(4'd11, 0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 5'd9);
    i_wb_src = 1;
    tick();
    drive_op(4'd1, 4'd1, 64'd1, 64'd1, 5'd4);
    #1;
    chk("mul_no_redirect", 64'(o_redirect), 0);
    n = 0;
    begin
      int bubble_bad;
      bubble_bad = 0;
      while (o_busy && n < 200) begin
        n++;
        if (o_valid_instr || o_rd_write || o_wb_src) bubble_bad++;
        tick();
      end
      chk("mul_bubbles", 64'(bubble_bad), 0);
    end
    chk("mul_busy_cycles", 64'(n), 64'd64);
    chk("mul_result", o_alu_data, 64'hFFFF_FFFF_FFFF_FFFD);
    chk("mul_ctl", {59'd0, o_valid_instr, o_rd_write, o_wb_src, o_rd_addr[1:0]},
        {59'd0, 1'b1, 1'b1, 1'b1, 2'b01});
    chk("mul_rd", 64'(o_rd_addr), 64'd9);
    drive_idle();
    tick();

    // Multiply 6 x 7 with a stall held across the final count.
    drive_op(4'd11, 0, 64'd6, 64'd7, 5'd12);
    tick();
    drive_idle();
    repeat (63) tick();
    chk("mul2_busy_pre", 64'(o_busy), 1);
    i_stall = 1;
    repeat (3) tick();
    chk("mul2_busy_stalled", 64'(o_busy), 1);
    chk("mul2_bubble_held", 64'(o_valid_instr), 0);
    i_stall = 0;
    tick();
    chk("mul2_busy_done", 64'(o_busy), 0);
    chk("mul2_result", o_alu_data, 64'd42);
    chk("mul2_rd", 64'(o_rd_addr), 64'd12);

    // Reset at multiply cycle 10, with enable low, clears everything.
    drive_op(4'd11, 0, 64'd5, 64'd5, 5'd7);
    tick();
    drive_idle();
    repeat (10) tick();
    chk("mul3_busy", 64'(o_busy), 1);
    reset = 1; enable = 0;
    drive_op(4'd1, 4'd1, 64'd2, 64'd2, 5'd5);
    #1;
    chk("reset_redirect", 64'(o_redirect), 0);
    tick();
    chk("mul3_reset_busy", 64'(o_busy), 0);
    chk("mul3_reset_outs", {o_alu_data[55:0], o_valid_instr, o_rd_write, o_rd_addr},
        64'd0);
    reset = 0; enable = 1;
    drive_idle();
    tick();
    chk("post_reset_idle", 64'(o_busy), 0);
    drive_op(4'd0, 0, 64'd2, 64'd2, 5'd1);
    tick();
    chk("post_reset_add", o_alu_data, 64'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/riscv_ex_stage.md
RISCV_EX_STAGE -- requirements
Module: riscv_ex_stage

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64: operand/result width; STRB_WIDTH = DATA_WIDTH/8 derived internally.
REQ-002 SHALL have parameter ADDR_WIDTH, default 64: PC/redirect width.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 enable  input  1  global enable; 0 freezes all state.
REQ-006 i_stall  input  1  downstream (mem stage) stall; hold outputs.
REQ-007 i_valid_instr  input  1  decode slot holds a valid instruction.
REQ-008 i_alu_op  input  4  0 ADD,1 SUB,2 SLL,3 SLT,4 SLTU,5 XOR,6 SRL,7 SRA,8 OR,9 AND,10 PASS_B,11 MUL; others yield 0.
REQ-009 i_br_op  input  4  0 none,1 BEQ,2 BNE,3 BLT,4 BGE,5 BLTU,6 BGEU,7 JAL,8 JALR.
REQ-010 i_op_a  input  DATA_WIDTH  operand A (forwarded rs1 or PC).
REQ-011 i_op_b  input  DATA_WIDTH  operand B (forwarded rs2 or imm).
REQ-012 i_pc  input  ADDR_WIDTH  instruction PC.
REQ-013 i_imm  input  DATA_WIDTH  sign-extended immediate.
REQ-014 i_rs2_data  input  DATA_WIDTH  store data.
REQ-015 i_mem_size  input  2  0 byte,1 half,2 word,3 dword.
REQ-016 i_rd_addr  input  5  destination register.
REQ-017 i_rd_write / i_read / i_write / i_wb_src  input  1 each  passed through to the mem stage.
REQ-018 o_busy  output  1  multiplier busy; decode holds its slot.
REQ-019 o_redirect  output  1  combinational taken branch/jump; flushes fetch/decode.
REQ-020 o_redirect_pc  output  ADDR_WIDTH  redirect target.
REQ-021 o_valid_instr / o_rd_write / o_read / o_write / o_wb_src  output  1 each  registered controls.
REQ-022 o_alu_data  output  DATA_WIDTH  registered result / memory address.
REQ-023 o_rs2_data  output  DATA_WIDTH  registered, lane-aligned store data.
REQ-024 o_mem_wr_strb  output  STRB_WIDTH  registered byte strobes.
REQ-025 o_rd_addr  output  5  registered destination.

Function
REQ-026 Accept = enable & !i_stall & state IDLE; on accept all outputs load next cycle (latency 1), except MUL.
REQ-027 enable=0 or i_stall=1: every output register and the FSM hold; o_redirect forced 0.
REQ-028 ALU: ADD/SUB modulo 2^DATA_WIDTH; shifts use i_op_b[log2(DATA_WIDTH)-1:0]; SLT signed, SLTU unsigned, result 0/1.
REQ-029 Branch compare i_op_a vs i_op_b; o_redirect = accept & i_valid_instr & condition; JAL/JALR always taken.
REQ-030 Target: branches/JAL i_pc+i_imm; JALR (i_op_a+i_imm) with bit 0 cleared; JAL/JALR o_alu_data = i_pc+4.
REQ-031 Store (i_write): strobe = size mask (0x1,0x3,0xF,0xFF) << o_alu_data[2:0], bits above STRB_WIDTH dropped; data = i_rs2_data << 8*addr[2:0]; non-store strobe 0.
REQ-032 MUL FSM IDLE->BUSY on accepted valid MUL; latch operands/controls; shift-add one bit per enabled cycle, DATA_WIDTH cycles; low DATA_WIDTH product bits.
REQ-033 In BUSY: o_busy=1; output register loads a bubble (all 1-bit controls 0) when !i_stall; i_valid_instr ignored.
REQ-034 Final count: if !i_stall load product with latched rd/controls, return IDLE; if i_stall, remain at final count until released.

Reset
REQ-035 reset=1 at clk edge: FSM IDLE, counter 0, all outputs 0 (incl. o_busy, o_redirect), regardless of enable or MUL in progress.

Verification
REQ-036 ADD op_a=5, op_b=-3 -> next cycle o_alu_data=2, o_valid_instr=1.
REQ-037 Store size 2, op_a=0x1000, op_b=4, rs2=0xDEADBEEF -> o_alu_data=0x1004, o_mem_wr_strb=0xF0, o_rs2_data=0xDEADBEEF_00000000.
REQ-038 BEQ 7==7, pc=0x100, imm=0x20 -> same cycle o_redirect=1, target 0x120; BNE same -> 0; JALR op_a=0x203, imm=0 -> 0x202, o_alu_data=pc+4.
REQ-039 MUL 3 x 0xFFFF_FFFF_FFFF_FFFF -> o_busy 64 cycles with bubbles, then o_alu_data=0xFFFF_FFFF_FFFF_FFFD, o_rd_write=1.
REQ-040 i_stall held 3 cycles -> outputs unchanged; reset at MUL cycle 10 -> o_busy=0, all outputs 0 next cycle.
